// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI constants, parser state type and message-length helper.
package midi_pkg;

  // Upper nibble of channel-voice status bytes
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  typedef enum logic [2:0] {
    WAIT_STATUS,
    WAIT_KEY,
    WAIT_VEL,
    SKIP1,
    SKIP2
  } parser_state_t;

  // Number of data bytes carried by a channel-voice message with this status nibble
  function automatic logic [1:0] data_bytes(input logic [3:0] nib);
    case (nib)
      PROG, CH_AT:                           return 2'd1;
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: return 2'd2;
      default:                               return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial byte receiver with input synchronizer, start-glitch
// rejection, one-cycle byte strobe and one-cycle framing-error pulse.
module midi_uart_rx #(
  parameter int CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_framing_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // r_sync[1:0] is the two-flop synchronizer, r_sync[2] the previous synced level
  logic [2:0]    r_sync;
  rx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_valid;
  logic          r_ferr;

  rx_state_t     w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_bit_next;
  logic [7:0]    w_shift_next;
  logic          w_byte_valid_next;
  logic          w_ferr_next;
  logic          w_rx;
  logic          w_rx_prev;
  logic          w_stop_sample;

  assign w_rx          = r_sync[1];
  assign w_rx_prev     = r_sync[2];
  assign w_stop_sample = (r_state == RX_STOP) && (r_cnt == BIT_LAST);

  // State register: synchronizer, receive FSM, bit counters and output strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync       <= 3'b111;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_sync       <= {r_sync[1:0], i_rx};
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit        <= w_bit_next;
      r_shift      <= w_shift_next;
      r_byte_valid <= w_byte_valid_next;
      r_ferr       <= w_ferr_next;
    end
  end

  // Next-state: half-bit to the start centre, then full bits for data and stop
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    case (r_state)
      RX_IDLE: begin
        w_cnt_next = '0;
        if (w_rx_prev && !w_rx) w_state_next = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next   = '0;
          w_bit_next   = '0;
          // Line back high at mid-start means a glitch, not a start bit
          w_state_next = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {w_rx, r_shift[7:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = RX_IDLE;
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  // Outputs: classify the stop-bit sample into a byte strobe or a framing error
  always_comb begin
    w_byte_valid_next = w_stop_sample && w_rx;
    w_ferr_next       = w_stop_sample && !w_rx;
  end

  assign o_byte        = r_shift;
  assign o_byte_valid  = r_byte_valid;
  assign o_framing_err = r_ferr;

endmodule

// File: rtl/midi_rx_parser.sv
// midi_rx_parser: MIDI input to monophonic, last-note-priority gate/key interface.
// Build option: define MIDI_RX_OMNI_EN to accept Note On/Off on all 16 channels.
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 31_250,
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [6:0] velocity,
  output logic       framing_err
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [7:0]    w_byte;
  logic          w_byte_valid;
  logic          w_uart_ferr;
  logic          w_chan_ok;
  logic [3:0]    w_nib;

  // r_run_nib holds the running-status nibble; zero means no running status
  parser_state_t r_state;
  logic [3:0]    r_run_nib;
  logic [6:0]    r_key;
  logic [6:0]    r_note;
  logic          r_valid;
  logic [6:0]    r_vel;
  logic          r_ferr;

  parser_state_t w_state_next;
  logic [3:0]    w_run_next;
  logic [6:0]    w_key_next;
  logic [6:0]    w_note_next;
  logic          w_valid_next;
  logic [6:0]    w_vel_next;

  midi_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (midi_rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_framing_err(w_uart_ferr)
  );

  assign w_nib = w_byte[7:4];

`ifdef MIDI_RX_OMNI_EN
  assign w_chan_ok = 1'b1;
`else
  assign w_chan_ok = (w_byte[3:0] == CHANNEL[3:0]);
`endif

  // State register: parser FSM, running status, latched key and note outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= WAIT_STATUS;
      r_run_nib <= '0;
      r_key     <= '0;
      r_note    <= '0;
      r_valid   <= 1'b0;
      r_vel     <= '0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_run_nib <= w_run_next;
      r_key     <= w_key_next;
      r_note    <= w_note_next;
      r_valid   <= w_valid_next;
      r_vel     <= w_vel_next;
      r_ferr    <= w_uart_ferr;
    end
  end

  // Next-state: byte classification, running status and skip counting
  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run_nib;
    w_key_next   = r_key;
    if (w_byte_valid) begin
      if (w_byte[7]) begin
        if (w_nib == 4'hF) begin
          // System common/exclusive cancels running status; real-time is transparent
          if (!w_byte[3]) begin
            w_run_next   = '0;
            w_state_next = WAIT_STATUS;
          end
        end else begin
          w_run_next = w_nib;
          if (((w_nib == NOTE_ON) || (w_nib == NOTE_OFF)) && w_chan_ok)
            w_state_next = WAIT_KEY;
          else if (data_bytes(w_nib) == 2'd1)
            w_state_next = SKIP1;
          else
            w_state_next = SKIP2;
        end
      end else begin
        case (r_state)
          WAIT_KEY: begin
            w_key_next   = w_byte[6:0];
            w_state_next = WAIT_VEL;
          end
          WAIT_VEL: w_state_next = WAIT_KEY;
          SKIP2:    w_state_next = SKIP1;
          SKIP1:    w_state_next = (data_bytes(r_run_nib) == 2'd2) ? SKIP2 : SKIP1;
          default:  w_state_next = WAIT_STATUS;
        endcase
      end
    end
  end

  // Outputs: apply a completed Note On/Off to the gate, key and velocity
  always_comb begin
    w_note_next  = r_note;
    w_valid_next = r_valid;
    w_vel_next   = r_vel;
    if (w_byte_valid && !w_byte[7] && (r_state == WAIT_VEL)) begin
      if ((r_run_nib == NOTE_ON) && (w_byte[6:0] != 7'd0)) begin
        w_note_next  = r_key;
        w_vel_next   = w_byte[6:0];
        w_valid_next = 1'b1;
      end else if ((r_key == r_note) && r_valid) begin
        // Key stays put so the release tail keeps its pitch
        w_valid_next = 1'b0;
      end
    end
  end

  assign midi_data   = {1'b0, r_note};
  assign midi_valid  = r_valid;
  assign velocity    = r_vel;
  assign framing_err = r_ferr;

endmodule
